// File: rtl/pipe_mult_pkg.sv
// Shared widths, stage count and the per-stage register bundle for pipe_mult.
package pipe_mult_pkg;

  localparam int NUM_STAGES     = 8;
  localparam int BITS_PER_STAGE = 8;
  localparam int DATA_W         = 64;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] partial;
    logic [DATA_W-1:0] mcand_s;
    logic [DATA_W-1:0] mplier_s;
  } stage_t;

endpackage

// File: rtl/mult_stage.sv
// One pipeline stage: multiply-accumulate one multiplier byte, then shift the operands.
// One cycle of latency; no backpressure, so the stage updates on every clock edge.
module mult_stage
  import pipe_mult_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  stage_t stage_in,
  output stage_t stage_out
);

  stage_t            stage_nxt;
  logic [DATA_W-1:0] digit;

  assign digit = {{(DATA_W-BITS_PER_STAGE){1'b0}}, stage_in.mplier_s[BITS_PER_STAGE-1:0]};

  // All arithmetic is DATA_W wide, so the high product bits fall away naturally.
  always_comb begin
    stage_nxt          = stage_in;
    stage_nxt.partial  = stage_in.partial + stage_in.mcand_s * digit;
    stage_nxt.mcand_s  = stage_in.mcand_s << BITS_PER_STAGE;
    stage_nxt.mplier_s = stage_in.mplier_s >> BITS_PER_STAGE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stage_out <= '0;
    else        stage_out <= stage_nxt;
  end

endmodule

// File: rtl/pipe_mult.sv
// 64x64 -> low-64 unsigned multiplier, 8-stage pipeline: fixed 8-cycle latency, one issue per cycle.
// No backpressure: done pulses for one cycle. PIPE_MULT_BUSY_EN adds a busy output.
module pipe_mult
  import pipe_mult_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] mcand,
  input  logic [DATA_W-1:0] mplier,
  input  logic              start,
  output logic [DATA_W-1:0] product,
  output logic              done
`ifdef PIPE_MULT_BUSY_EN
  ,
  output logic              busy
`endif
);

  stage_t pipe [NUM_STAGES+1];

  // Bubbles carry zero operands so product stays deterministic while done is low.
  assign pipe[0].valid    = start;
  assign pipe[0].partial  = '0;
  assign pipe[0].mcand_s  = start ? mcand  : '0;
  assign pipe[0].mplier_s = start ? mplier : '0;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    mult_stage u_stage (
      .clock     (clock),
      .reset     (reset),
      .stage_in  (pipe[g]),
      .stage_out (pipe[g+1])
    );
  end

  assign product = pipe[NUM_STAGES].partial;
  assign done    = pipe[NUM_STAGES].valid;

  // After the last stage both operands are fully consumed.
  logic unused_tail;
  assign unused_tail = ^{pipe[NUM_STAGES].mcand_s, pipe[NUM_STAGES].mplier_s};

`ifdef PIPE_MULT_BUSY_EN
  logic [NUM_STAGES-1:0] stage_vld;
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_vld
    assign stage_vld[g] = pipe[g+1].valid;
  end
  assign busy = |stage_vld;
`endif

endmodule

// File: doc/pipe_mult.md
PIPE_MULT -- requirements
Module: pipe_mult

Interface
REQ-001 SHALL have port: clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; clears all state while low.
REQ-003 SHALL have port: mcand  input  64  unsigned multiplicand, sampled on the clock edge where start=1.
REQ-004 SHALL have port: mplier  input  64  unsigned multiplier, sampled on the clock edge where start=1.
REQ-005 SHALL have port: start  input  1  one-cycle request; launches one multiply per cycle high.
REQ-006 SHALL have port: product  output  64  low 64 bits of mcand*mplier; valid only while done=1.
REQ-007 SHALL have port: done  output  1  one-cycle pulse per completed request.
REQ-008 SHALL have parameter: none; stage count and widths come from the package.

Function
REQ-009 SHALL be an 8-stage pipeline; each stage consumes 8 multiplier bits, LSB group first.
REQ-010 Each stage SHALL compute partial += mcand_s * mplier_s[7:0], then mcand_s <<= 8 and mplier_s >>= 8, all 64-bit, truncating.
REQ-011 Each stage SHALL register partial, mcand_s, mplier_s and a valid bit on every clock edge.
REQ-012 start high in cycle k SHALL produce done=1 with the matching product in cycle k+8 exactly; fixed latency, no stall.
REQ-013 SHALL accept a new start every cycle (throughput 1/cycle); results SHALL exit in issue order.
REQ-014 start low SHALL inject a bubble; a bubble SHALL NOT produce a done pulse.
REQ-015 product SHALL hold the final-stage partial register; its value while done=0 is don't-care but SHALL be deterministic (registered).
REQ-016 Arithmetic SHALL be unsigned; product SHALL equal (mcand*mplier) mod 2^64.
REQ-017 There SHALL be no backpressure; the consumer SHALL take product in the done cycle.

Reset
REQ-018 reset low SHALL asynchronously clear every valid bit, partial, mcand_s and mplier_s to 0.
REQ-019 Outputs during/after reset: done=0, product=0 (and busy=0 when compiled in).
REQ-020 Reset mid-operation SHALL discard all in-flight requests; none SHALL ever signal done.
REQ-021 start sampled on the first edge after reset release SHALL be accepted normally.

Configuration
REQ-022 Macro PIPE_MULT_BUSY_EN SHALL, when defined, add output busy (1 bit): high whenever any stage valid bit is set.
REQ-023 With PIPE_MULT_BUSY_EN defined, busy SHALL be high from cycle k+1 through k+8 for a lone start in cycle k.
REQ-024 Without PIPE_MULT_BUSY_EN, the busy port and its OR-reduction SHALL NOT exist; all other behaviour unchanged.

Structure
REQ-025 Package pipe_mult_pkg SHALL hold NUM_STAGES=8, BITS_PER_STAGE=8, DATA_W=64 and the stage-register struct typedef (valid, partial, mcand_s, mplier_s).
REQ-026 Sub-module mult_stage SHALL implement one stage (combinational MAC/shift plus its register bank), instantiated NUM_STAGES times via generate.
REQ-027 Stage 0 SHALL take mcand/mplier/start with partial=0; stage 7 outputs SHALL drive product/done directly.

Verification
REQ-028 start=1 in cycle k with mcand=3, mplier=5 -> done=1 only in cycle k+8, product=15.
REQ-029 Back-to-back starts k..k+3 with (2,3), (0xFFFFFFFF,0xFFFFFFFF), (0,123), (1,1) -> done k+8..k+11, products 6, 0xFFFFFFFE00000001, 0, 1.
REQ-030 mcand=0xFFFFFFFFFFFFFFFF, mplier=2 -> product 0xFFFFFFFFFFFFFFFE (truncation).
REQ-031 start in cycles k and k+3 -> done high in k+8 and k+11 only, low in k+9 and k+10.
REQ-032 start in cycle k, reset low for one cycle at k+4 -> done never asserts for that request; product=0 and done=0 through k+12.
REQ-033 PIPE_MULT_BUSY_EN defined, lone start in cycle k -> busy low in k, high k+1..k+8, low k+9.
